// File: rtl/bp_fe_pkg.sv
// ---------------------------------------------------------------------------
// bp_fe_pkg
//   Shared front-end predictor definitions.
//   - DECLARE_BP_FE_BP_UPDATE_ENTRY_S(idx_width): declares the packed entry
//     struct {idx, taken} held by the branch predictor update queue. It is a
//     macro because the index width is a module parameter.
//   - BP_FE_BP_UPDATE_ENTRY_WIDTH(idx_width): bit width of that struct.
//   - Default parameter values and the pointer-width helper.
// ---------------------------------------------------------------------------
`ifndef BP_FE_PKG_SV
`define BP_FE_PKG_SV

`define DECLARE_BP_FE_BP_UPDATE_ENTRY_S(idx_width_mp) \
  typedef struct packed { \
    logic [idx_width_mp-1:0] idx; \
    logic                    taken; \
  } bp_fe_bp_update_entry_s

`define BP_FE_BP_UPDATE_ENTRY_WIDTH(idx_width_mp) ((idx_width_mp) + 1)

package bp_fe_pkg;

  localparam int bp_fe_bht_idx_width_dflt_lp = 9;
  localparam int bp_fe_depth_dflt_lp         = 8;
  localparam int bp_fe_cnt_width_dflt_lp     = 16;

  // Pointer width for a circular buffer of 'depth' entries. The extra MSB
  // is the wrap bit that distinguishes full from empty.
  function automatic int bp_fe_ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

`endif

// File: rtl/bp_fe_bp_update_mem.sv
// ---------------------------------------------------------------------------
// bp_fe_bp_update_mem
//   Storage for the update queue: els_p x width_p register array with one
//   synchronous write port and one asynchronous read port. Not reset.
//
//   clk_i      in   clock
//   w_v_i      in   write enable
//   w_addr_i   in   write address
//   w_data_i   in   write data
//   r_addr_i   in   read address
//   r_data_o   out  read data (combinational from r_addr_i)
// ---------------------------------------------------------------------------
module bp_fe_bp_update_mem
  import bp_fe_pkg::*;
#(
  parameter  int width_p       = bp_fe_bht_idx_width_dflt_lp + 1,
  parameter  int els_p         = bp_fe_depth_dflt_lp,
  localparam int addr_width_lp = $clog2(els_p)
) (
  input  logic                     clk_i,
  input  logic                     w_v_i,
  input  logic [addr_width_lp-1:0] w_addr_i,
  input  logic [width_p-1:0]       w_data_i,
  input  logic [addr_width_lp-1:0] r_addr_i,
  output logic [width_p-1:0]       r_data_o
);

  logic [width_p-1:0] mem_q [els_p];
  logic [width_p-1:0] mem_d [els_p];

  always_comb begin
    mem_d = mem_q;
    if (w_v_i) begin
      mem_d[w_addr_i] = w_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  assign r_data_o = mem_q[r_addr_i];

endmodule

// File: rtl/bp_fe_bp_update_queue.sv
// ---------------------------------------------------------------------------
// bp_fe_bp_update_queue
//   Records each front-end prediction {BHT index, predicted direction} in
//   program order and pairs it with the in-order resolution from the back
//   end, emitting one registered predictor training update per resolved
//   branch. Flush drops all wrong-path entries.
//
//   clk_i, reset_i         clock, asynchronous active-high reset
//   pred_v_i/idx/taken     new prediction; accepted when pred_ready_o
//   pred_ready_o           not full
//   res_v_i, res_taken_i   oldest branch resolved, actual direction
//   res_ready_o            not empty
//   flush_i                discard all in-flight entries
//   w_v_o/idx_w_o/correct_o  registered predictor update (1-cycle latency)
//   count_o                occupancy 0..depth_p
//   underflow_o            pulse: resolve seen while empty
//   mispredict_cnt_o       saturating mispredict counter
// ---------------------------------------------------------------------------
module bp_fe_bp_update_queue
  import bp_fe_pkg::*;
#(
  parameter  int bht_idx_width_p = bp_fe_bht_idx_width_dflt_lp,
  parameter  int depth_p         = bp_fe_depth_dflt_lp,
  parameter  int cnt_width_p     = bp_fe_cnt_width_dflt_lp,
  localparam int ptr_width_lp    = bp_fe_ptr_width(depth_p)
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       pred_v_i,
  input  logic [bht_idx_width_p-1:0] pred_idx_i,
  input  logic                       pred_taken_i,
  output logic                       pred_ready_o,
  input  logic                       res_v_i,
  input  logic                       res_taken_i,
  output logic                       res_ready_o,
  input  logic                       flush_i,
  output logic                       w_v_o,
  output logic [bht_idx_width_p-1:0] idx_w_o,
  output logic                       correct_o,
  output logic [ptr_width_lp-1:0]    count_o,
  output logic                       underflow_o,
  output logic [cnt_width_p-1:0]     mispredict_cnt_o
);

  `DECLARE_BP_FE_BP_UPDATE_ENTRY_S(bht_idx_width_p);

  localparam int entry_width_lp = `BP_FE_BP_UPDATE_ENTRY_WIDTH(bht_idx_width_p);
  localparam int addr_width_lp  = ptr_width_lp - 1;

  logic [ptr_width_lp-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic                       w_v_q, w_v_d;
  logic [bht_idx_width_p-1:0] idx_w_q, idx_w_d;
  logic                       correct_q, correct_d;
  logic                       underflow_q, underflow_d;
  logic [cnt_width_p-1:0]     cnt_q, cnt_d;

  logic full, empty, enq, deq, mismatch;
  bp_fe_bp_update_entry_s wr_entry, rd_entry;

  // Flags come from registered pointers only, so the ready outputs have no
  // combinational dependence on any input.
  assign full  = (wr_q[ptr_width_lp-1] != rd_q[ptr_width_lp-1])
              && (wr_q[addr_width_lp-1:0] == rd_q[addr_width_lp-1:0]);
  assign empty = (wr_q == rd_q);

  // No bypass: a full queue rejects the enqueue even if a slot is freed this
  // cycle, and an empty queue cannot resolve a same-cycle enqueue. A flush
  // drops the same-cycle enqueue but still honours a valid resolve, which
  // belongs to a branch older than the flushed path.
  assign enq      = pred_v_i && !full && !flush_i;
  assign deq      = res_v_i && !empty;
  assign mismatch = (rd_entry.taken != res_taken_i);

  assign wr_entry.idx   = pred_idx_i;
  assign wr_entry.taken = pred_taken_i;

  bp_fe_bp_update_mem #(
    .width_p (entry_width_lp),
    .els_p   (depth_p)
  ) u_mem (
    .clk_i    (clk_i),
    .w_v_i    (enq),
    .w_addr_i (wr_q[addr_width_lp-1:0]),
    .w_data_i (wr_entry),
    .r_addr_i (rd_q[addr_width_lp-1:0]),
    .r_data_o (rd_entry)
  );

  always_comb begin
    wr_d        = wr_q + ptr_width_lp'(enq);
    rd_d        = rd_q + ptr_width_lp'(deq);
    w_v_d       = deq;
    idx_w_d     = idx_w_q;
    correct_d   = correct_q;
    underflow_d = res_v_i && empty;
    cnt_d       = cnt_q;

    if (flush_i) begin
      wr_d = '0;
      rd_d = '0;
    end

    // Update payload holds its previous value when no branch resolves.
    if (deq) begin
      idx_w_d   = rd_entry.idx;
      correct_d = !mismatch;
      if (mismatch && (cnt_q != '1)) begin
        cnt_d = cnt_q + cnt_width_p'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_q        <= '0;
      rd_q        <= '0;
      w_v_q       <= 1'b0;
      idx_w_q     <= '0;
      correct_q   <= 1'b0;
      underflow_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      w_v_q       <= w_v_d;
      idx_w_q     <= idx_w_d;
      correct_q   <= correct_d;
      underflow_q <= underflow_d;
      cnt_q       <= cnt_d;
    end
  end

  assign pred_ready_o     = !full;
  assign res_ready_o      = !empty;
  assign count_o          = wr_q - rd_q;
  assign w_v_o            = w_v_q;
  assign idx_w_o          = idx_w_q;
  assign correct_o        = correct_q;
  assign underflow_o      = underflow_q;
  assign mispredict_cnt_o = cnt_q;

endmodule

// File: tb/tb_bp_fe_bp_update_queue.sv
// ---------------------------------------------------------------------------
// tb_bp_fe_bp_update_queue
//   Self-checking bench for bp_fe_bp_update_queue. A queue model tracks the
//   in-flight predictions; expected updates are pushed when a resolve is
//   driven and popped when the DUT presents its update. A second instance
//   with a 2-bit mispredict counter shares all inputs to check saturation.
// ---------------------------------------------------------------------------
module tb_bp_fe_bp_update_queue;

  localparam int bht_idx_width_lp = 9;
  localparam int depth_lp         = 8;
  localparam int ptr_width_lp     = 4;
  localparam int cnt_width_lp     = 16;
  localparam int sat_width_lp     = 2;

  typedef struct {
    logic [bht_idx_width_lp-1:0] idx;
    logic                        taken;
  } pred_t;

  typedef struct {
    logic [bht_idx_width_lp-1:0] idx;
    logic                        correct;
  } upd_t;

  logic                        clk_i = 1'b0;
  logic                        reset_i;
  logic                        pred_v_i;
  logic [bht_idx_width_lp-1:0] pred_idx_i;
  logic                        pred_taken_i;
  logic                        res_v_i;
  logic                        res_taken_i;
  logic                        flush_i;

  logic                        pred_ready_o, res_ready_o, w_v_o, correct_o, underflow_o;
  logic [bht_idx_width_lp-1:0] idx_w_o;
  logic [ptr_width_lp-1:0]     count_o;
  logic [cnt_width_lp-1:0]     mispredict_cnt_o;

  logic                        sat_pred_ready, sat_res_ready, sat_w_v, sat_correct, sat_underflow;
  logic [bht_idx_width_lp-1:0] sat_idx_w;
  logic [ptr_width_lp-1:0]     sat_count;
  logic [sat_width_lp-1:0]     sat_cnt;

  pred_t model_fifo[$];
  upd_t  exp_q[$];
  int    model_mcnt;
  logic  exp_wv;
  logic  exp_uf;

  int n_vec = 0;
  int n_err = 0;

  bp_fe_bp_update_queue #(
    .bht_idx_width_p (bht_idx_width_lp),
    .depth_p         (depth_lp),
    .cnt_width_p     (cnt_width_lp)
  ) u_dut (
    .clk_i            (clk_i),
    .reset_i          (reset_i),
    .pred_v_i         (pred_v_i),
    .pred_idx_i       (pred_idx_i),
    .pred_taken_i     (pred_taken_i),
    .pred_ready_o     (pred_ready_o),
    .res_v_i          (res_v_i),
    .res_taken_i      (res_taken_i),
    .res_ready_o      (res_ready_o),
    .flush_i          (flush_i),
    .w_v_o            (w_v_o),
    .idx_w_o          (idx_w_o),
    .correct_o        (correct_o),
    .count_o          (count_o),
    .underflow_o      (underflow_o),
    .mispredict_cnt_o (mispredict_cnt_o)
  );

  bp_fe_bp_update_queue #(
    .bht_idx_width_p (bht_idx_width_lp),
    .depth_p         (depth_lp),
    .cnt_width_p     (sat_width_lp)
  ) u_dut_sat (
    .clk_i            (clk_i),
    .reset_i          (reset_i),
    .pred_v_i         (pred_v_i),
    .pred_idx_i       (pred_idx_i),
    .pred_taken_i     (pred_taken_i),
    .pred_ready_o     (sat_pred_ready),
    .res_v_i          (res_v_i),
    .res_taken_i      (res_taken_i),
    .res_ready_o      (sat_res_ready),
    .flush_i          (flush_i),
    .w_v_o            (sat_w_v),
    .idx_w_o          (sat_idx_w),
    .correct_o        (sat_correct),
    .count_o          (sat_count),
    .underflow_o      (sat_underflow),
    .mispredict_cnt_o (sat_cnt)
  );

  // Free-running 100 MHz clock.
  always #5 clk_i = ~clk_i;

  // Drive one cycle of stimulus and advance the model: the resolve pops the
  // oldest prediction and queues the expected update; the enqueue is applied
  // against the occupancy seen at the start of the cycle (no bypass).
  // Outputs are sampled 1 ns after the clock edge.
  task automatic drive(input logic pv, input logic [bht_idx_width_lp-1:0] pidx,
                       input logic pt, input logic rv, input logic rt, input logic fl);
    pred_t e;
    upd_t  u;
    int    sz;
    sz     = model_fifo.size();
    exp_wv = 1'b0;
    exp_uf = rv && (sz == 0);
    if (rv && (sz != 0)) begin
      e         = model_fifo.pop_front();
      u.idx     = e.idx;
      u.correct = (e.taken == rt);
      exp_q.push_back(u);
      exp_wv = 1'b1;
      if (e.taken != rt) model_mcnt++;
    end
    if (fl) begin
      model_fifo.delete();
    end else if (pv && (sz < depth_lp)) begin
      e.idx   = pidx;
      e.taken = pt;
      model_fifo.push_back(e);
    end
    pred_v_i     = pv;
    pred_idx_i   = pidx;
    pred_taken_i = pt;
    res_v_i      = rv;
    res_taken_i  = rt;
    flush_i      = fl;
    @(posedge clk_i);
    #1;
    pred_v_i = 1'b0;
    res_v_i  = 1'b0;
    flush_i  = 1'b0;
  endtask

  function automatic int sat_expect(input int v);
    return (v > 3) ? 3 : v;
  endfunction

  // Reset state, checked while reset is still asserted.
  task automatic test_reset();
    logic [31:0] act [8];
    logic [31:0] req [8];
    string       nm  [8];
    reset_i = 1'b1; pred_v_i = 1'b0; pred_idx_i = '0; pred_taken_i = 1'b0;
    res_v_i = 1'b0; res_taken_i = 1'b0; flush_i = 1'b0;
    model_fifo.delete(); exp_q.delete(); model_mcnt = 0;
    #1;
    act = '{32'(w_v_o), 32'(count_o), 32'(pred_ready_o), 32'(res_ready_o),
            32'(underflow_o), 32'(mispredict_cnt_o), 32'(idx_w_o), 32'(correct_o)};
    req = '{32'd0, 32'd0, 32'd1, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    nm  = '{"rst_w_v", "rst_count", "rst_pred_ready", "rst_res_ready",
            "rst_underflow", "rst_mcnt", "rst_idx_w", "rst_correct"};
    for (int i = 0; i < 8; i++) begin
      n_vec++;
      if (act[i] !== req[i]) begin
        n_err++;
        $display("[TB] FAIL %s: got %0h expected %0h", nm[i], act[i], req[i]);
      end
    end
    repeat (2) @(posedge clk_i);
    #1;
    reset_i = 1'b0;
  endtask

  // Three predictions, three in-order resolves, one mispredict.
  task automatic test_basic();
    upd_t u;
    drive(1'b1, 9'd5,  1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 9'd9,  1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 9'd12, 1'b1, 1'b0, 1'b0, 1'b0);
    n_vec++;
    if (count_o !== 4'd3) begin
      n_err++; $display("[TB] FAIL basic_count_fill: got %0d expected 3", count_o);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 9'd0, 1'b0, 1'b1, 1'b1, 1'b0);
      n_vec++;
      if (w_v_o !== exp_wv) begin
        n_err++; $display("[TB] FAIL basic_w_v: got %0b expected %0b", w_v_o, exp_wv);
      end
      if (exp_wv) begin
        u = exp_q.pop_front();
        n_vec++;
        if (idx_w_o !== u.idx || correct_o !== u.correct) begin
          n_err++;
          $display("[TB] FAIL basic_update: got (%0d,%0b) expected (%0d,%0b)",
                   idx_w_o, correct_o, u.idx, u.correct);
        end
      end
    end
    drive(1'b0, 9'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_vec++;
    if (w_v_o !== 1'b0) begin
      n_err++; $display("[TB] FAIL basic_w_v_idle: got %0b expected 0", w_v_o);
    end
    n_vec++;
    if (mispredict_cnt_o !== 16'(model_mcnt) || model_mcnt != 1) begin
      n_err++; $display("[TB] FAIL basic_mcnt: got %0d expected 1", mispredict_cnt_o);
    end
    n_vec++;
    if (count_o !== 4'd0) begin
      n_err++; $display("[TB] FAIL basic_count_end: got %0d expected 0", count_o);
    end
  endtask

  // Fill to depth, then a same-cycle enqueue/resolve only dequeues.
  task automatic test_full();
    upd_t u;
    for (int i = 0; i < depth_lp; i++) begin
      drive(1'b1, 9'(100 + i), 1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0);
    end
    n_vec++;
    if (pred_ready_o !== 1'b0) begin
      n_err++; $display("[TB] FAIL full_pred_ready: got %0b expected 0", pred_ready_o);
    end
    n_vec++;
    if (count_o !== 4'd8) begin
      n_err++; $display("[TB] FAIL full_count: got %0d expected 8", count_o);
    end
    drive(1'b1, 9'd200, 1'b1, 1'b1, 1'b1, 1'b0);
    n_vec++;
    if (count_o !== 4'd7 || pred_ready_o !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL full_simul: got count %0d ready %0b expected count 7 ready 1",
               count_o, pred_ready_o);
    end
    // Drain what is left, checking program order on the way out.
    for (int i = 0; i < depth_lp; i++) begin
      if (i > 0) drive(1'b0, 9'd0, 1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'b0);
      n_vec++;
      if (w_v_o !== exp_wv) begin
        n_err++; $display("[TB] FAIL full_w_v: got %0b expected %0b", w_v_o, exp_wv);
      end
      if (exp_wv) begin
        u = exp_q.pop_front();
        n_vec++;
        if (idx_w_o !== u.idx || correct_o !== u.correct) begin
          n_err++;
          $display("[TB] FAIL full_update: got (%0d,%0b) expected (%0d,%0b)",
                   idx_w_o, correct_o, u.idx, u.correct);
        end
      end
    end
    n_vec++;
    if (res_ready_o !== 1'b0 || count_o !== 4'd0) begin
      n_err++; $display("[TB] FAIL full_drained: got count %0d expected 0", count_o);
    end
  endtask

  // Resolve while empty with a same-cycle enqueue: underflow only.
  task automatic test_underflow();
    upd_t u;
    drive(1'b1, 9'd42, 1'b0, 1'b1, 1'b0, 1'b0);
    n_vec++;
    if (underflow_o !== exp_uf || exp_uf !== 1'b1) begin
      n_err++; $display("[TB] FAIL uf_pulse: got %0b expected 1", underflow_o);
    end
    n_vec++;
    if (w_v_o !== 1'b0) begin
      n_err++; $display("[TB] FAIL uf_w_v: got %0b expected 0", w_v_o);
    end
    n_vec++;
    if (count_o !== 4'd1) begin
      n_err++; $display("[TB] FAIL uf_count: got %0d expected 1", count_o);
    end
    drive(1'b0, 9'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    n_vec++;
    if (underflow_o !== 1'b0) begin
      n_err++; $display("[TB] FAIL uf_one_cycle: got %0b expected 0", underflow_o);
    end
    u = exp_q.pop_front();
    n_vec++;
    if (w_v_o !== 1'b1 || idx_w_o !== u.idx || correct_o !== u.correct) begin
      n_err++;
      $display("[TB] FAIL uf_update: got (%0b,%0d,%0b) expected (1,%0d,%0b)",
               w_v_o, idx_w_o, correct_o, u.idx, u.correct);
    end
  endtask

  // Flush with a same-cycle resolve and enqueue.
  task automatic test_flush();
    upd_t u;
    drive(1'b1, 9'd3,  1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 9'd21, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 9'd22, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 9'd23, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 9'd77, 1'b1, 1'b1, 1'b0, 1'b1);
    u = exp_q.pop_front();
    n_vec++;
    if (w_v_o !== 1'b1 || idx_w_o !== 9'd3 || correct_o !== 1'b0 || u.idx != 9'd3) begin
      n_err++;
      $display("[TB] FAIL flush_update: got (%0b,%0d,%0b) expected (1,3,0)",
               w_v_o, idx_w_o, correct_o);
    end
    n_vec++;
    if (count_o !== 4'd0 || res_ready_o !== 1'b0) begin
      n_err++; $display("[TB] FAIL flush_count: got %0d expected 0", count_o);
    end
    drive(1'b0, 9'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_vec++;
    if (w_v_o !== 1'b0 || idx_w_o !== 9'd3 || correct_o !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL flush_hold: got (%0b,%0d,%0b) expected (0,3,0)",
               w_v_o, idx_w_o, correct_o);
    end
    n_vec++;
    if (mispredict_cnt_o !== 16'(model_mcnt)) begin
      n_err++; $display("[TB] FAIL flush_mcnt: got %0d expected %0d", mispredict_cnt_o, model_mcnt);
    end
  endtask

  // 20 predictions streamed with continuous pointer wrap, then saturation.
  task automatic test_back_to_back();
    upd_t u;
    for (int i = 0; i < 22; i++) begin
      drive(i < 20, 9'($urandom_range(0, 511)), 1'($urandom_range(0, 1)),
            i >= 2, 1'($urandom_range(0, 1)), 1'b0);
      n_vec++;
      if (w_v_o !== exp_wv) begin
        n_err++; $display("[TB] FAIL wrap_w_v[%0d]: got %0b expected %0b", i, w_v_o, exp_wv);
      end
      if (exp_wv) begin
        u = exp_q.pop_front();
        n_vec++;
        if (idx_w_o !== u.idx || correct_o !== u.correct) begin
          n_err++;
          $display("[TB] FAIL wrap_update[%0d]: got (%0d,%0b) expected (%0d,%0b)",
                   i, idx_w_o, correct_o, u.idx, u.correct);
        end
      end
      n_vec++;
      if (count_o !== 4'(model_fifo.size())) begin
        n_err++;
        $display("[TB] FAIL wrap_count[%0d]: got %0d expected %0d", i, count_o, model_fifo.size());
      end
    end
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 9'(300 + i), 1'b1, 1'b0, 1'b0, 1'b0);
      drive(1'b0, 9'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      void'(exp_q.pop_front());
    end
    n_vec++;
    if (sat_cnt !== 2'(sat_expect(model_mcnt)) || sat_cnt !== 2'd3) begin
      n_err++; $display("[TB] FAIL sat_mcnt: got %0d expected 3", sat_cnt);
    end
    n_vec++;
    if (mispredict_cnt_o !== 16'(model_mcnt)) begin
      n_err++; $display("[TB] FAIL wide_mcnt: got %0d expected %0d", mispredict_cnt_o, model_mcnt);
    end
  endtask

  // Asynchronous reset off the clock edge with entries and an update live.
  task automatic test_async_reset();
    logic [31:0] act [5];
    logic [31:0] req [5];
    string       nm  [5];
    upd_t        u;
    for (int i = 0; i < 3; i++) drive(1'b1, 9'(400 + i), 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 9'd403, 1'b1, 1'b1, 1'b1, 1'b0);
    n_vec++;
    if (w_v_o !== 1'b1 || count_o !== 4'd3) begin
      n_err++; $display("[TB] FAIL arst_pre: got w_v %0b count %0d expected 1 3", w_v_o, count_o);
    end
    #2;
    reset_i = 1'b1;
    #1;
    act = '{32'(w_v_o), 32'(count_o), 32'(res_ready_o), 32'(mispredict_cnt_o), 32'(pred_ready_o)};
    req = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd1};
    nm  = '{"arst_w_v", "arst_count", "arst_res_ready", "arst_mcnt", "arst_pred_ready"};
    for (int i = 0; i < 5; i++) begin
      n_vec++;
      if (act[i] !== req[i]) begin
        n_err++;
        $display("[TB] FAIL %s: got %0h expected %0h", nm[i], act[i], req[i]);
      end
    end
    model_fifo.delete(); exp_q.delete(); model_mcnt = 0;
    @(posedge clk_i);
    #3;
    reset_i = 1'b0;
    @(posedge clk_i);
    #1;
    drive(1'b1, 9'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 9'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    u = exp_q.pop_front();
    n_vec++;
    if (w_v_o !== 1'b1 || idx_w_o !== u.idx || correct_o !== u.correct) begin
      n_err++;
      $display("[TB] FAIL arst_recover: got (%0b,%0d,%0b) expected (1,%0d,%0b)",
               w_v_o, idx_w_o, correct_o, u.idx, u.correct);
    end
  endtask

  // Scenario sequence and summary.
  initial begin
    test_reset();
    test_basic();
    test_full();
    test_underflow();
    test_flush();
    test_back_to_back();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Guard against a stuck run.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/bp_fe_bp_update_queue.md
Name: bp_fe_bp_update_queue

Overview:
- Update-side writer for the front-end branch predictor's training port (w_v_i / idx_w_i / correct_i).
- Records every prediction the front end makes (BHT index plus predicted direction) in program order.
- Matches each prediction against the in-order resolution from the back end and drives one registered predictor update per resolved branch.
- Sits between the fetch-stage predictor read and the backend branch-resolution interface; discards wrong-path entries on flush.

Parameters:
- bht_idx_width_p, 9: BHT index width; must match the predictor instance.
- depth_p, 8: number of in-flight predictions tracked; power of two, >= 2.
- ptr_width_lp, $clog2(depth_p)+1 (localparam): pointer width, including the wrap bit.
- cnt_width_p, 16: width of the mispredict statistics counter.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  asynchronous, active-high reset
- pred_v_i  in  1  new prediction valid
- pred_idx_i  in  bht_idx_width_p  BHT index used for the prediction
- pred_taken_i  in  1  predicted direction
- pred_ready_o  out  1  queue can accept a prediction (not full)
- res_v_i  in  1  oldest in-flight branch resolved
- res_taken_i  in  1  actual branch direction
- res_ready_o  out  1  queue holds at least one entry
- flush_i  in  1  discard all in-flight entries
- w_v_o  out  1  predictor update valid
- idx_w_o  out  bht_idx_width_p  predictor update index
- correct_o  out  1  prediction was correct
- count_o  out  ptr_width_lp  current occupancy, 0..depth_p
- underflow_o  out  1  one-cycle pulse: res_v_i asserted while empty
- mispredict_cnt_o  out  cnt_width_p  saturating mispredict count

Behaviour:
- Reset (asynchronous, active-high) takes effect immediately:
  - read and write pointers = 0, count_o = 0;
  - w_v_o, idx_w_o, correct_o, underflow_o = 0; mispredict_cnt_o = 0;
  - pred_ready_o = 1, res_ready_o = 0;
  - storage contents are don't-care.
  - Reset in mid-operation drops all entries and any pending update.
- Storage: circular buffer with wrap-bit pointers.
  - full = (wr[msb] != rd[msb]) && (low bits equal).
  - empty = (wr == rd).
  - count_o = wr - rd, modulo 2^ptr_width_lp.
- Ready signals:
  - pred_ready_o = !full; res_ready_o = !empty.
  - Both are decoded from registered state only; no combinational path from inputs.
- Enqueue: on pred_v_i && pred_ready_o, write {pred_idx_i, pred_taken_i} at wr and increment wr.
  - pred_v_i while full is ignored; the producer must hold it.
- Resolve: on res_v_i && res_ready_o, read the entry at rd (asynchronous read) and increment rd.
  - Next cycle: w_v_o = 1, idx_w_o = entry idx, correct_o = (entry taken == res_taken_i).
  - Latency is exactly one cycle; at most one update per cycle; w_v_o otherwise 0.
- Simultaneous enqueue and resolve while neither full nor empty: both occur and count is unchanged.
- No bypasses:
  - While empty, a same-cycle enqueue is not resolvable; res_v_i sets underflow_o = 1 for the next cycle only and has no other effect.
  - While full, a same-cycle resolve does not free a slot for that cycle's enqueue.
- Flush: on flush_i, next state wr = rd = 0 and the same-cycle enqueue is dropped.
  - A same-cycle valid resolve is still accepted and produces its update, because the resolving branch precedes the flushed wrong path.
  - The outputs idx_w_o and correct_o hold their last values while w_v_o = 0.
- Statistics: mispredict_cnt_o increments by 1 on each accepted resolve with a mismatch and saturates at all-ones (no wrap).
- Index widths are identical throughout; no truncation or extension.

Decomposition:
- bp_fe_pkg gets the bp_fe_bp_update_entry_s typedef {logic [bht_idx_width_p-1:0] idx; logic taken;}, parameterised via a width macro, matching existing package practice.
- Sub-module bp_fe_bp_update_mem: depth_p x entry register array with 1 synchronous write port and 1 asynchronous read port, no reset.
- The top level holds the pointers, flags, update output register and statistics counter.

Test Plan:
- Reset, then enqueue idx 5/T, 9/N, 12/T. Resolve T, T, T on consecutive cycles. Expect:
  - w_v_o high on cycles 1 to 3 after each resolve;
  - updates (5,correct_o=1), (9,0), (12,1);
  - mispredict_cnt_o = 1 and count_o = 0 at the end.
- Fill 8 entries: expect pred_ready_o = 0 and count_o = 8. Then pred_v_i and res_v_i in the same cycle: expect only the dequeue, count_o = 7 and pred_ready_o = 1 next cycle.
- res_v_i while empty, with pred_v_i in the same cycle: expect underflow_o pulses for 1 cycle, w_v_o = 0, count_o = 1.
- With 4 entries (first idx 3/T), assert flush_i with res_v_i, res_taken_i = 0, and pred_v_i. Expect next cycle w_v_o = 1, idx_w_o = 3, correct_o = 0, count_o = 0, and the new prediction dropped.
- Enqueue/resolve 20 entries with continuous wrap: expect every update in program order. Then, with cnt_width_p = 2, force 5 mispredicts: expect mispredict_cnt_o stays at 3.
- Assert reset_i mid-stream, off the clock edge, with 3 entries and w_v_o = 1. Expect immediately w_v_o = 0, count_o = 0, res_ready_o = 0 and mispredict_cnt_o = 0.
